regbus_arbiter: RTL and testbench

REGBUS_ARBITER -- requirements
Module: regbus_arbiter

---
 rtl/regbus_arbiter.sv | 154 +++++++++++++++
 tb/tb_regbus_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regbus_arbiter
//  Description : Two-requester round-robin arbiter in front of a single
//                register-bus slave, with a per-access ack timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module regbus_arbiter #(
   parameter int TIMEOUT_CYC = 15,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [2*ADDR_W-1:0]   addr,
   input  logic [2*DATA_W-1:0]   wdata,
   output logic [1:0]            done,
   output logic [1:0]            err,
   output logic [DATA_W-1:0]     rdata,
   output logic                  s_vld,
   output logic                  s_we,
   output logic [ADDR_W-1:0]     s_addr,
   output logic [DATA_W-1:0]     s_wdata,
   input  logic                  s_ack,
   input  logic [DATA_W-1:0]     s_rdata,
   output logic                  busy,
   output logic                  owner
);

   localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last;
   logic                r_owner;
   logic                r_err;
   logic                r_s_we;
   logic [ADDR_W-1:0]   r_s_addr;
   logic [DATA_W-1:0]   r_s_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [7:0]          r_cnt;
   logic                w_grant;
   logic                w_timeout;
   logic [1:0]          w_owner_oh;

   // Round-robin pick: on contention the previous loser wins
   always_comb begin
      w_grant = req[1];
      if (req == 2'b11) begin
         w_grant = ~r_last;
      end
   end

   assign w_timeout  = (r_cnt == C_TIMEOUT);
   assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      w_state_nxt = r_state;
      s_vld       = 1'b0;
      busy        = 1'b1;
      done        = 2'b00;
      err         = 2'b00;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (|req) begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            s_vld = 1'b1;
            // An ack in the timeout cycle still completes normally
            if (s_ack || w_timeout) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            done        = w_owner_oh;
            err         = r_err ? w_owner_oh : 2'b00;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Grant capture, slave request latching, timeout count and response data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last    <= 1'b1;
         r_owner   <= 1'b0;
         r_err     <= 1'b0;
         r_s_we    <= 1'b0;
         r_s_addr  <= '0;
         r_s_wdata <= '0;
         r_rdata   <= '0;
         r_cnt     <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_owner   <= w_grant;
                  r_last    <= w_grant;
                  r_s_we    <= we[w_grant];
                  r_s_addr  <= w_grant ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                  r_s_wdata <= w_grant ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                  r_cnt     <= 8'd1;
                  r_err     <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (s_ack) begin
                  r_rdata <= r_s_we ? '0 : s_rdata;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign s_we    = r_s_we;
   assign s_addr  = r_s_addr;
   assign s_wdata = r_s_wdata;
   assign rdata   = r_rdata;
   assign owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_regbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbus_arbiter
//  Description : Directed scoreboard bench for regbus_arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regbus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [15:0] addr;
   logic [63:0] wdata;
   logic [1:0]  done;
   logic [1:0]  err;
   logic [31:0] rdata;
   logic        s_vld;
   logic        s_we;
   logic [7:0]  s_addr;
   logic [31:0] s_wdata;
   logic        s_ack;
   logic [31:0] s_rdata;
   logic        busy;
   logic        owner;

   typedef struct packed {
      logic [1:0]  done;
      logic [1:0]  err;
      logic [31:0] rdata;
   } sb_t;

   sb_t   sb[$];
   int    checks = 0;
   int    errors = 0;
   time   t_resp;
   time   t_prev;

   regbus_arbiter #(.TIMEOUT_CYC(4), .ADDR_W(8), .DATA_W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .done    (done),
      .err     (err),
      .rdata   (rdata),
      .s_vld   (s_vld),
      .s_we    (s_we),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_ack   (s_ack),
      .s_rdata (s_rdata),
      .busy    (busy),
      .owner   (owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done pulse must match the oldest expected response
   always @(negedge clk) begin
      if (done !== 2'b00 || err !== 2'b00) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got done=%b err=%b expected none", done, err);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("done", 64'(done), 64'(e.done));
            chk("err", 64'(err), 64'(e.err));
            chk("rdata", 64'(rdata), 64'(e.rdata));
         end
      end
   end

   // One access from grant to response; leaves the bench 1ns into the next IDLE
   task automatic access(input logic [1:0] rq, input logic [1:0] w, input int ack_at,
                         input logic [31:0] sr, input logic exp_own, input logic [7:0] exp_addr,
                         input int exp_vld, input logic exp_to, input logic [31:0] exp_rd,
                         input bit hold, input bit chg);
      sb_t         e;
      int          n;
      logic [31:0] ew;
      e.done  = exp_own ? 2'b10 : 2'b01;
      e.err   = exp_to ? e.done : 2'b00;
      e.rdata = exp_rd;
      sb.push_back(e);
      ew  = exp_own ? wdata[63:32] : wdata[31:0];
      req = rq;
      we  = w;
      step();
      chk("owner", 64'(owner), 64'(exp_own));
      chk("busy", 64'(busy), 64'd1);
      n = 0;
      while (s_vld === 1'b1 && n < 20) begin
         n++;
         chk("s_addr", 64'(s_addr), 64'(exp_addr));
         chk("s_we", 64'(s_we), 64'(w[exp_own]));
         chk("s_wdata", 64'(s_wdata), 64'(ew));
         if (chg && n == 1) addr = 16'h2020;
         if (n == ack_at) begin
            s_ack   = 1'b1;
            s_rdata = sr;
         end
         step();
         s_ack   = 1'b0;
         s_rdata = 32'h0BAD0BAD;
      end
      chk("vld_cycles", 64'(n), 64'(exp_vld));
      t_resp = $time;
      if (!hold) req = 2'b00;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      req     = 2'b00;
      we      = 2'b00;
      addr    = 16'h0000;
      wdata   = 64'h0;
      s_ack   = 1'b0;
      s_rdata = 32'h0;
      repeat (3) step();
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      chk("rst_s_vld", 64'(s_vld), 64'd0);
      chk("rst_s_we", 64'(s_we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      chk("rst_s_wdata", 64'(s_wdata), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
      rst = 1'b0;

      // Contention after reset: owners 0,1,0,1 with done every 3 cycles
      addr  = 16'hB1A0;
      wdata = 64'h11111111_00000000;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         access(2'b11, 2'b00, 1, 32'h1000 + k, k[0], k[0] ? 8'hB1 : 8'hA0,
                1, 1'b0, 32'h1000 + k, 1'b1, 1'b0);
         if (k > 0) chk("done_spacing", 64'(t_resp - t_prev), 64'd30);
         t_prev = t_resp;
      end
      req = 2'b00;
      step();

      // Single read acked in the 2nd BUSY cycle
      addr = 16'h003C;
      access(2'b01, 2'b00, 2, 32'hDEADBEEF, 1'b0, 8'h3C, 2, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);

      // Write: response data forced to zero
      addr  = 16'h5A3C;
      wdata = 64'hCAFEF00D_00000000;
      access(2'b10, 2'b10, 1, 32'hFFFFFFFF, 1'b1, 8'h5A, 1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Timeout: no ack, 4 BUSY cycles then err
      access(2'b10, 2'b10, 0, 32'h0, 1'b1, 8'h5A, 4, 1'b1, 32'h0, 1'b0, 1'b0);

      // Ack in the timeout cycle wins
      access(2'b01, 2'b00, 4, 32'h55AA1234, 1'b0, 8'h3C, 4, 1'b0, 32'h55AA1234, 1'b0, 1'b0);

      // Address change while BUSY does not reach the slave
      addr = 16'h1010;
      access(2'b01, 2'b00, 3, 32'h12345678, 1'b0, 8'h10, 3, 1'b0, 32'h12345678, 1'b0, 1'b1);

      // Reset in BUSY cycle 2, with a coincident ack
      addr = 16'h0077;
      req  = 2'b01;
      we   = 2'b00;
      step();
      chk("mid_s_vld_b1", 64'(s_vld), 64'd1);
      step();
      rst     = 1'b1;
      s_ack   = 1'b1;
      s_rdata = 32'hFEEDFACE;
      step();
      rst   = 1'b0;
      s_ack = 1'b0;
      req   = 2'b00;
      chk("mid_rst_s_vld", 64'(s_vld), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_s_addr", 64'(s_addr), 64'd0);
      repeat (2) step();

      // After reset requester 0 wins contention again
      addr = 16'hB177;
      access(2'b11, 2'b00, 1, 32'h0000A5A5, 1'b0, 8'h77, 1, 1'b0, 32'h0000A5A5, 1'b0, 1'b0);

      repeat (3) step();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
